ship_bullet_pool: RTL and testbench

//  Multi-shot bullet controller for the ship. Manages c_NumBullets independent

---
 rtl/bullet_pkg.sv | 30 +++
 rtl/bullet_slot.sv | 51 +++++
 rtl/ship_bullet_pool.sv | 145 ++++++++++++++
 tb/tb_ship_bullet_pool.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and helpers for the ship bullet pool: board coordinate type and
// the lowest-free-slot picker used by the launch logic.
package bullet_pkg;

    localparam int c_CoordW   = 6;
    localparam int c_MaxSlots = 8;
    localparam int c_SlotIdxW = 3;

    typedef logic [c_CoordW-1:0] coord_t;

    typedef struct packed {
        logic                  found;
        logic [c_SlotIdxW-1:0] index;
    } free_slot_t;

    // free_mask bit k = 1 means slot k can take a new bullet
    function automatic free_slot_t lowest_free(input logic [c_MaxSlots-1:0] free_mask);
        free_slot_t r;
        r.found = 1'b0;
        r.index = '0;
        for (int k = c_MaxSlots - 1; k >= 0; k--) begin
            if (free_mask[k]) begin
                r.found = 1'b1;
                r.index = k[c_SlotIdxW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: live flag plus X/Y position. Clear beats launch beats hit
// beats move; the match bit flags the board cell currently being scanned.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int c_SpawnRow = 28
)
(
    input  logic   i_Clk,
    input  logic   i_Reset,
    input  logic   i_Launch,
    input  coord_t i_LaunchX,
    input  logic   i_Tick,
    input  logic   i_Hit,
    input  logic   i_Clear,
    input  coord_t i_Col,
    input  coord_t i_Row,
    output logic   o_Active,
    output coord_t o_X,
    output coord_t o_Y,
    output logic   o_Match
);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Active <= 1'b0;
            o_X      <= '0;
            o_Y      <= '0;
        end else if (i_Clear) begin
            o_Active <= 1'b0;
        end else if (i_Launch) begin
            o_Active <= 1'b1;
            o_X      <= i_LaunchX;
            o_Y      <= coord_t'(c_SpawnRow);
        end else if (o_Active) begin
            // A hit retires the bullet where it stands, even on a tick
            if (i_Hit) begin
                o_Active <= 1'b0;
            end else if (i_Tick) begin
                if (o_Y == '0) begin
                    o_Active <= 1'b0;
                end else begin
                    o_Y <= o_Y - 1'b1;
                end
            end
        end
    end

    assign o_Match = o_Active && (o_X == i_Col) && (o_Y == i_Row);

endmodule

// File: rtl/ship_bullet_pool.sv
// Multi-shot bullet controller: move-tick counter, launch cooldown, fire edge
// detect, lowest-free-slot launch and the registered draw hit for the VGA mux.
module ship_bullet_pool
    import bullet_pkg::*;
#(
    parameter int c_GameWidth  = 40,
    parameter int c_GameHeight = 30,
    parameter int c_NumBullets = 4,
    parameter int c_BullSpeed  = 1250000,
    parameter int c_Cooldown   = 3,
    parameter int c_SpawnRow   = 28,
    parameter int c_XOffset    = 2
)
(
    input  logic                             i_Clk,
    input  logic                             i_Reset,
    input  logic                             i_GameActive,
    input  logic                             i_Shoot,
    input  logic [c_CoordW-1:0]              i_ShipX,
    input  logic [c_CoordW-1:0]              i_ColCountDiv,
    input  logic [c_CoordW-1:0]              i_RowCountDiv,
    input  logic [c_NumBullets-1:0]          i_HitMask,
    output logic                             o_DrawBull,
    output logic [c_NumBullets-1:0]          o_BullActive,
    output logic [c_CoordW*c_NumBullets-1:0] o_BullX,
    output logic [c_CoordW*c_NumBullets-1:0] o_BullY,
    output logic                             o_Fired
);

    localparam int c_CntW  = (c_BullSpeed > 1) ? $clog2(c_BullSpeed) : 1;
    localparam int c_CoolW = (c_Cooldown > 0) ? $clog2(c_Cooldown + 1) : 1;
    localparam logic [c_CntW-1:0]   c_CntLast = c_CntW'(c_BullSpeed - 1);
    localparam logic [c_CoolW-1:0]  c_CoolLd  = c_CoolW'(c_Cooldown);
    localparam logic [c_CoordW:0]   c_XMax    = (c_CoordW + 1)'(c_GameWidth - 1);
    localparam logic [c_CoordW:0]   c_XOff    = (c_CoordW + 1)'(c_XOffset);

    logic [c_CntW-1:0]       r_TickCount;
    logic [c_CoolW-1:0]      r_Cooldown;
    logic                    r_ShootPrev;
    logic                    w_Tick;
    logic                    w_FireReq;
    logic                    w_Launch;
    logic [c_MaxSlots-1:0]   w_FreeMask;
    free_slot_t              w_FreeSel;
    logic [c_CoordW:0]       w_LaunchXWide;
    coord_t                  w_LaunchX;
    logic [c_NumBullets-1:0] w_SlotLaunch;
    logic [c_NumBullets-1:0] w_SlotMatch;

    assign w_Tick    = (r_TickCount == c_CntLast);
    assign w_FireReq = i_Shoot & ~r_ShootPrev;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_TickCount <= '0;
        end else if (!i_GameActive || w_Tick) begin
            r_TickCount <= '0;
        end else begin
            r_TickCount <= r_TickCount + 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_ShootPrev <= 1'b0;
        end else begin
            r_ShootPrev <= i_Shoot;
        end
    end

    // Free slots come from the registered flags, so a slot retiring this
    // cycle only becomes a launch target on the following cycle.
    always_comb begin
        w_FreeMask                   = '0;
        w_FreeMask[c_NumBullets-1:0] = ~o_BullActive;
    end

    assign w_FreeSel = lowest_free(w_FreeMask);
    assign w_Launch  = w_FireReq & i_GameActive & (r_Cooldown == '0) & w_FreeSel.found;

    always_comb begin
        w_LaunchXWide = {1'b0, i_ShipX} + c_XOff;
        if (w_LaunchXWide > c_XMax) begin
            w_LaunchXWide = c_XMax;
        end
        w_LaunchX = w_LaunchXWide[c_CoordW-1:0];
    end

    always_comb begin
        w_SlotLaunch = '0;
        for (int k = 0; k < c_NumBullets; k++) begin
            w_SlotLaunch[k] = w_Launch && (w_FreeSel.index == c_SlotIdxW'(k));
        end
    end

    // A launch reloads the cooldown even when it lands on a tick
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_Cooldown <= '0;
        end else if (!i_GameActive) begin
            r_Cooldown <= '0;
        end else if (w_Launch) begin
            r_Cooldown <= c_CoolLd;
        end else if (w_Tick && (r_Cooldown != '0)) begin
            r_Cooldown <= r_Cooldown - 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Fired <= 1'b0;
        end else begin
            o_Fired <= w_Launch;
        end
    end

    for (genvar k = 0; k < c_NumBullets; k++) begin : g_slot
        bullet_slot #(
            .c_SpawnRow (c_SpawnRow)
        ) u_slot (
            .i_Clk     (i_Clk),
            .i_Reset   (i_Reset),
            .i_Launch  (w_SlotLaunch[k]),
            .i_LaunchX (w_LaunchX),
            .i_Tick    (w_Tick),
            .i_Hit     (i_HitMask[k]),
            .i_Clear   (~i_GameActive),
            .i_Col     (i_ColCountDiv),
            .i_Row     (i_RowCountDiv),
            .o_Active  (o_BullActive[k]),
            .o_X       (o_BullX[c_CoordW*k +: c_CoordW]),
            .o_Y       (o_BullY[c_CoordW*k +: c_CoordW]),
            .o_Match   (w_SlotMatch[k])
        );
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_DrawBull <= 1'b0;
        end else begin
            o_DrawBull <= |w_SlotMatch;
        end
    end

endmodule

// File: tb/tb_ship_bullet_pool.sv
// Randomized plus directed bench for ship_bullet_pool, checked cycle by cycle
// against a behavioural bullet model through an expected-response queue.
module tb_ship_bullet_pool;

    localparam int N     = 4;
    localparam int SPEED = 4;
    localparam int COOL  = 2;
    localparam int WIDTH = 40;
    localparam int SPAWN = 28;
    localparam int XOFF  = 2;

    logic           clk;
    logic           rst;
    logic           game;
    logic           shoot;
    logic [5:0]     shipx;
    logic [5:0]     col;
    logic [5:0]     row;
    logic [N-1:0]   hit;
    logic           o_DrawBull;
    logic [N-1:0]   o_BullActive;
    logic [6*N-1:0] o_BullX;
    logic [6*N-1:0] o_BullY;
    logic           o_Fired;

    typedef struct {
        logic [N-1:0]   act;
        logic [6*N-1:0] bx;
        logic [6*N-1:0] by;
        logic           fired;
        logic           draw;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int model_fires = 0;
    int dut_fires = 0;

    // behavioural model state
    int m_act[N];
    int m_x[N];
    int m_y[N];
    int m_phase;
    int m_cd;
    int m_prev;

    ship_bullet_pool #(
        .c_GameWidth  (WIDTH),
        .c_GameHeight (30),
        .c_NumBullets (N),
        .c_BullSpeed  (SPEED),
        .c_Cooldown   (COOL),
        .c_SpawnRow   (SPAWN),
        .c_XOffset    (XOFF)
    ) dut (
        .i_Clk         (clk),
        .i_Reset       (rst),
        .i_GameActive  (game),
        .i_Shoot       (shoot),
        .i_ShipX       (shipx),
        .i_ColCountDiv (col),
        .i_RowCountDiv (row),
        .i_HitMask     (hit),
        .o_DrawBull    (o_DrawBull),
        .o_BullActive  (o_BullActive),
        .o_BullX       (o_BullX),
        .o_BullY       (o_BullY),
        .o_Fired       (o_Fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the game rules to one clock edge with the inputs currently driven
    task automatic model_step();
        exp_t e;
        int   draw, tick, launch, idx, lx;
        draw = 0;
        for (int k = 0; k < N; k++)
            if (m_act[k] != 0 && m_x[k] == int'(col) && m_y[k] == int'(row)) draw = 1;
        tick = (game && m_phase == SPEED - 1) ? 1 : 0;
        idx = -1;
        for (int k = N - 1; k >= 0; k--)
            if (m_act[k] == 0) idx = k;
        launch = (shoot && m_prev == 0 && game && m_cd == 0 && idx >= 0) ? 1 : 0;
        lx = int'(shipx) + XOFF;
        if (lx > WIDTH - 1) lx = WIDTH - 1;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_act[k] = 0;
                m_x[k]   = 0;
                m_y[k]   = 0;
            end
            m_phase = 0;
            m_cd    = 0;
            m_prev  = 0;
            launch  = 0;
            draw    = 0;
        end else begin
            m_phase = (!game || tick != 0) ? 0 : m_phase + 1;
            if (!game) m_cd = 0;
            else if (launch != 0) m_cd = COOL;
            else if (tick != 0 && m_cd > 0) m_cd = m_cd - 1;
            for (int k = 0; k < N; k++) begin
                if (!game) begin
                    m_act[k] = 0;
                end else if (launch != 0 && k == idx) begin
                    m_act[k] = 1;
                    m_x[k]   = lx;
                    m_y[k]   = SPAWN;
                end else if (m_act[k] != 0) begin
                    if (hit[k]) m_act[k] = 0;
                    else if (tick != 0) begin
                        if (m_y[k] == 0) m_act[k] = 0;
                        else m_y[k] = m_y[k] - 1;
                    end
                end
            end
            m_prev = shoot ? 1 : 0;
        end
        for (int k = 0; k < N; k++) begin
            e.act[k]       = (m_act[k] != 0);
            e.bx[6*k +: 6] = 6'(m_x[k]);
            e.by[6*k +: 6] = 6'(m_y[k]);
        end
        e.fired = (launch != 0);
        e.draw  = (draw != 0);
        model_fires += launch;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [6*N-1:0] got, input logic [6*N-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("active", {{(5*N){1'b0}}, o_BullActive}, {{(5*N){1'b0}}, e.act});
            check("bull_x", o_BullX, e.bx);
            check("bull_y", o_BullY, e.by);
            check("fired", {{(6*N-1){1'b0}}, o_Fired}, {{(6*N-1){1'b0}}, e.fired});
            check("draw", {{(6*N-1){1'b0}}, o_DrawBull}, {{(6*N-1){1'b0}}, e.draw});
            if (o_Fired === 1'b1) dut_fires++;
        end
    end

    task automatic aim_at_bullet();
        int j;
        j = $urandom_range(0, N - 1);
        if (m_act[j] != 0 && $urandom_range(0, 1) == 1) begin
            col = 6'(m_x[j]);
            row = 6'(m_y[j]);
        end else begin
            col = 6'($urandom_range(0, 39));
            row = 6'($urandom_range(0, 29));
        end
    endtask

    initial begin
        int bound;
        rst = 1'b1; game = 1'b0; shoot = 1'b0; shipx = '0; col = '0; row = '0; hit = '0;
        for (int k = 0; k < N; k++) begin
            m_act[k] = 0; m_x[k] = 0; m_y[k] = 0;
        end
        m_phase = 0; m_cd = 0; m_prev = 0;
        steps(3);
        rst = 1'b0; game = 1'b1;
        steps(2);

        // single launch from ShipX=10, then button held for 20 ticks
        shipx = 6'd10; shoot = 1'b1;
        steps(80);
        shoot = 1'b0;
        steps(2);

        // draw sweep around slot 0
        for (int c = 9; c < 16; c++) begin
            for (int r = -1; r <= 1; r++) begin
                col = 6'(c);
                row = 6'(m_y[0] + r);
                step();
            end
        end

        // fill the pool at the right edge (X clamps), fifth shot has no slot
        shipx = 6'd39;
        for (int s = 0; s < 6; s++) begin
            shoot = 1'b1; step();
            shoot = 1'b0; steps(11);
        end
        // quick re-fire inside the cooldown window
        shoot = 1'b1; step(); shoot = 1'b0; step();
        shoot = 1'b1; step(); shoot = 1'b0; steps(10);

        // hit slot 1 on a tick edge
        bound = 0;
        while (m_phase != SPEED - 1 && bound < 10) begin
            step();
            bound++;
        end
        hit = 4'b0010; step(); hit = '0;
        steps(2);
        shipx = 6'd5; shoot = 1'b1; step(); shoot = 1'b0; steps(6);

        // game inactive clears everything
        game = 1'b0; steps(4); game = 1'b1; steps(2);

        // single bullet flies to the top row and retires
        shipx = 6'd20; shoot = 1'b1; step(); shoot = 1'b0;
        steps(130);

        // randomized play
        for (int i = 0; i < 2500; i++) begin
            rst   = ($urandom_range(0, 599) == 0);
            game  = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 3) == 0) shoot = ~shoot;
            if ($urandom_range(0, 7) == 0) shipx = 6'($urandom_range(0, 63));
            hit   = ($urandom_range(0, 11) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0;
            aim_at_bullet();
            step();
        end
        rst = 1'b0; game = 1'b1; hit = '0; shoot = 1'b0;
        steps(2);

        bound = 0;
        while (exp_q.size() > 0 && bound < 10) begin
            @(negedge clk);
            #1;
            bound++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        n_vec++;
        if (dut_fires != model_fires) begin
            n_err++;
            $display("FAIL fire_count: got %0d required %0d", dut_fires, model_fires);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
